// File: rtl/mac_sequencer_pkg.sv
// Shared definitions for the MAC sequencer: FSM encoding, pipeline depth,
// result FIFO depth and an address-width helper.
package mac_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int MAC_LAT    = 4;
    localparam int FIFO_DEPTH = 2;

    // Never returns 0, so single-entry RAMs still get a 1-bit address.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mac_sequencer_result_fifo.sv
// Small result FIFO with valid/ready pop; push and pop may coincide, even when
// full, because the head is read out combinationally before the write lands.
module result_fifo
    import mac_sequencer_pkg::*;
#(
    parameter int N     = 8,
    parameter int DEPTH = FIFO_DEPTH,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [N-1:0]  push_data,
    input  logic          ready,
    output logic          valid,
    output logic [N-1:0]  data,
    output logic [CW-1:0] count
);
    localparam int PW = addr_w(DEPTH);

    logic [N-1:0]  mem_reg [DEPTH];
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] wr_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          pop;

    assign valid = (count_reg != '0);
    assign data  = mem_reg[rd_ptr_reg];
    assign count = count_reg;
    assign pop   = valid && ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) mem_reg[k] <= '0;
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                mem_reg[wr_ptr_reg] <= push_data;
                wr_ptr_reg <= (wr_ptr_reg == PW'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (pop)
                rd_ptr_reg <= (rd_ptr_reg == PW'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
            if (push && !pop)
                count_reg <= count_reg + 1'b1;
            else if (pop && !push)
                count_reg <= count_reg - 1'b1;
        end
    end

endmodule

// File: rtl/mac_sequencer.sv
// Walks weight/input RAMs into a single MAC engine, one neuron at a time,
// and streams one downscaled result per neuron out through a 2-entry FIFO.
module mac_sequencer
    import mac_sequencer_pkg::*;
#(
    parameter int N         = 8,
    parameter int N_INPUTS  = 16,
    parameter int N_NEURONS = 4,
    parameter int WA_W      = addr_w(N_INPUTS * N_NEURONS),
    parameter int XA_W      = addr_w(N_INPUTS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            w_rd_en,
    output logic [WA_W-1:0] w_addr,
    input  logic [N-1:0]    w_data,
    output logic            x_rd_en,
    output logic [XA_W-1:0] x_addr,
    input  logic [N-1:0]    x_data,
    output logic [N-1:0]    mac_weight,
    output logic [N-1:0]    mac_in,
    output logic            mac_reset,
    output logic            mac_forget,
    output logic            mac_oe,
    input  logic [N-1:0]    mac_out,
    output logic            res_valid,
    output logic [N-1:0]    res_data,
    input  logic            res_ready
);
    localparam int TOTAL = N_INPUTS * N_NEURONS;
    localparam int CW    = $clog2(FIFO_DEPTH + 1);

    state_t            state_reg;
    logic [WA_W-1:0]   w_addr_reg;
    logic [XA_W-1:0]   i_reg;
    logic [1:0]        inflight_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              mac_reset_reg;
    logic [N-1:0]      mac_weight_reg;
    logic [N-1:0]      mac_in_reg;
    logic              valid_reg;
    logic [MAC_LAT-2:0] first_pipe_reg;
    logic [MAC_LAT-1:0] last_pipe_reg;
    logic [CW-1:0]     fifo_count;

    logic issue;
    logic first_smp;
    logic last_smp;
    logic last_all;

    // A new neuron needs a guaranteed FIFO slot for its result before it starts.
    assign issue     = (state_reg == ST_ISSUE) &&
                       ((i_reg != '0) || (int'(fifo_count) + int'(inflight_reg) < FIFO_DEPTH));
    assign first_smp = issue && (i_reg == '0);
    assign last_smp  = issue && (i_reg == XA_W'(N_INPUTS - 1));
    assign last_all  = last_smp && (w_addr_reg == WA_W'(TOTAL - 1));

    assign w_rd_en    = issue;
    assign x_rd_en    = issue;
    assign w_addr     = w_addr_reg;
    assign x_addr     = i_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign mac_reset  = mac_reset_reg;
    assign mac_weight = mac_weight_reg;
    assign mac_in     = mac_in_reg;
    assign mac_forget = first_pipe_reg[MAC_LAT-2];
    assign mac_oe     = last_pipe_reg[MAC_LAT-1];

    // Sample tags ride alongside the RAM/MAC data: stage 0 is RAM data valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_reg      <= 1'b0;
            first_pipe_reg <= '0;
            last_pipe_reg  <= '0;
            mac_weight_reg <= '0;
            mac_in_reg     <= '0;
        end else begin
            valid_reg      <= issue;
            first_pipe_reg <= {first_pipe_reg[MAC_LAT-3:0], first_smp};
            last_pipe_reg  <= {last_pipe_reg[MAC_LAT-2:0], last_smp};
            mac_weight_reg <= valid_reg ? w_data : '0;
            mac_in_reg     <= valid_reg ? x_data : '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            w_addr_reg    <= '0;
            i_reg         <= '0;
            inflight_reg  <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            mac_reset_reg <= 1'b0;
        end else begin
            done_reg      <= 1'b0;
            mac_reset_reg <= 1'b0;

            if (first_smp && !mac_oe)
                inflight_reg <= inflight_reg + 2'd1;
            else if (mac_oe && !first_smp)
                inflight_reg <= inflight_reg - 2'd1;

            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        state_reg     <= ST_PREP;
                        busy_reg      <= 1'b1;
                        mac_reset_reg <= 1'b1;
                    end
                end
                ST_PREP: begin
                    state_reg  <= ST_ISSUE;
                    w_addr_reg <= '0;
                    i_reg      <= '0;
                end
                ST_ISSUE: begin
                    if (issue) begin
                        w_addr_reg <= last_all ? '0 : w_addr_reg + 1'b1;
                        i_reg      <= last_smp ? '0 : i_reg + 1'b1;
                        if (last_all) state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (inflight_reg == '0) begin
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    busy_reg  <= 1'b0;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    result_fifo #(.N(N), .DEPTH(FIFO_DEPTH), .CW(CW)) u_result_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (mac_oe),
        .push_data (mac_out),
        .ready     (res_ready),
        .valid     (res_valid),
        .data      (res_data),
        .count     (fifo_count)
    );

endmodule
